// File: rtl/mic_pkg.sv
// Shared definitions for the microphone measurement sequencer.
// Contents:
//   BCD_W / CNT_W        digit width and edge-count width
//   MAX_COUNT_DEFAULT    saturation limit of the per-window edge count
//   gate_state_t         gate window FSM encoding
//   conv_state_t         sequential BCD converter FSM encoding
//   bcd4_t               four packed BCD digits, most significant first
package mic_pkg;

  localparam int BCD_W             = 4;
  localparam int CNT_W             = 14;
  localparam int MAX_COUNT_DEFAULT = 9999;

  typedef enum logic {
    G_IDLE = 1'b0,
    G_OPEN = 1'b1
  } gate_state_t;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_SHIFT = 2'd1,
    C_PUB   = 2'd2
  } conv_state_t;

  typedef struct packed {
    logic [BCD_W-1:0] thousands;
    logic [BCD_W-1:0] hundreds;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd4_t;

endpackage

// File: rtl/mic_measure_sequencer_if.sv
// Signal bundle between the measurement sequencer and its environment.
// Signals:
//   enable       1 = run back-to-back gate windows
//   mic_in       raw mic comparator input, asynchronous to clk
//   thousands..ones  published BCD digits
//   update       one-cycle strobe in the cycle the digits change
//   overflow     last published window saturated
//   gate_active  a gate window is open
// Modports:
//   master  drives enable/mic_in, observes results (environment side)
//   slave   the sequencer itself
interface mic_measure_sequencer_if;
  import mic_pkg::*;

  logic             enable;
  logic             mic_in;
  logic [BCD_W-1:0] thousands;
  logic [BCD_W-1:0] hundreds;
  logic [BCD_W-1:0] tens;
  logic [BCD_W-1:0] ones;
  logic             update;
  logic             overflow;
  logic             gate_active;

  modport master (
    output enable, mic_in,
    input  thousands, hundreds, tens, ones, update, overflow, gate_active
  );

  modport slave (
    input  enable, mic_in,
    output thousands, hundreds, tens, ones, update, overflow, gate_active
  );

endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter.
// A start pulse while idle captures bin; CNT_W shift cycles follow, then one
// cycle with done=1 during which d3..d0 hold the result. Starts that arrive
// while busy are ignored.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         capture bin and begin a conversion (ignored when busy)
//   bin           binary value, at most 9999
//   busy          conversion in progress (shift or publish cycle)
//   done          one cycle, result valid on d3..d0
//   d3..d0        BCD digits, d3 most significant
module bcd_seq_converter
  import mic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] d3,
  output logic [BCD_W-1:0] d2,
  output logic [BCD_W-1:0] d1,
  output logic [BCD_W-1:0] d0
);

  conv_state_t        state;
  conv_state_t        state_nxt;
  logic [CNT_W-1:0]   bin_q;
  logic [4*BCD_W-1:0] bcd_q;
  logic [4*BCD_W-1:0] bcd_adj;
  logic [3:0]         iter_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= C_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      C_IDLE:  if (start) state_nxt = C_SHIFT;
      C_SHIFT: if (iter_q == 4'(CNT_W - 1)) state_nxt = C_PUB;
      C_PUB:   state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  // Double-dabble correction: any digit >= 5 gets +3 before the shift so the
  // doubling carries correctly into the next decade.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5)
        bcd_adj[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
    end else begin
      unique case (state)
        C_IDLE: begin
          if (start) begin
            bin_q  <= bin;
            bcd_q  <= '0;
            iter_q <= '0;
          end
        end
        C_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          iter_q         <= iter_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != C_IDLE);
  assign done = (state == C_PUB);
  assign d3   = bcd_q[3*BCD_W +: BCD_W];
  assign d2   = bcd_q[2*BCD_W +: BCD_W];
  assign d1   = bcd_q[1*BCD_W +: BCD_W];
  assign d0   = bcd_q[0*BCD_W +: BCD_W];

endmodule

// File: rtl/mic_measure_sequencer.sv
// Microphone measurement sequencer.
// Synchronizes mic_in, counts its rising edges during fixed gate windows of
// GATE_CYCLES clocks, saturates at MAX_COUNT, converts each completed
// window's count to BCD and publishes it with a one-cycle update strobe,
// 16 cycles after the last window cycle.
// Ports:
//   clk   100 MHz system clock
//   rst   asynchronous active-high reset
//   bus   slave side of mic_measure_sequencer_if
//         (enable, mic_in in; thousands/hundreds/tens/ones, update,
//          overflow, gate_active out)
module mic_measure_sequencer
  import mic_pkg::*;
#(
  parameter int GATE_CYCLES = 100_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COUNT   = MAX_COUNT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  mic_measure_sequencer_if.slave bus
);

  localparam int WIN_W = $clog2(GATE_CYCLES);

  // ---------------- synchronizer and rising-edge detect ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   mic_prev;
  logic                   edge_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      mic_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.mic_in};
      mic_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~mic_prev;

  // ---------------- gate FSM and window counter ----------------
  gate_state_t      gate_state;
  gate_state_t      gate_nxt;
  logic [WIN_W-1:0] win_q;
  logic             win_last;
  logic             win_run;    // window open and not being aborted this cycle
  logic             handoff;    // window completes at the end of this cycle

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gate_state <= G_IDLE;
    else     gate_state <= gate_nxt;
  end

  always_comb begin
    gate_nxt = gate_state;
    win_last = (win_q == WIN_W'(GATE_CYCLES - 1));
    win_run  = (gate_state == G_OPEN) && bus.enable;
    handoff  = win_run && win_last;
    unique case (gate_state)
      G_IDLE: if (bus.enable)  gate_nxt = G_OPEN;
      G_OPEN: if (!bus.enable) gate_nxt = G_IDLE;
    endcase
  end

  // The counter sits at 0 whenever the gate is idle, so a new window always
  // starts from cycle 0; wrapping at the last cycle gives back-to-back windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       win_q <= '0;
    else if (win_run && !win_last) win_q <= win_q + WIN_W'(1);
    else                           win_q <= '0;
  end

  // ---------------- saturating edge counter ----------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_sum;
  logic             ovf_q;
  logic             ovf_sum;

  // cnt_sum/ovf_sum include this cycle's edge, so an edge in the last window
  // cycle is part of the value handed to the converter.
  always_comb begin
    cnt_sum = cnt_q;
    ovf_sum = ovf_q;
    if (edge_pulse) begin
      if (cnt_q == CNT_W'(MAX_COUNT)) ovf_sum = 1'b1;
      else                            cnt_sum = cnt_q + CNT_W'(1);
    end
  end

  // Cleared when idle, on abort and at handoff: an edge in cycle 0 of the
  // next window then counts from a clean start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (win_run && !win_last) begin
      cnt_q <= cnt_sum;
      ovf_q <= ovf_sum;
    end else begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end
  end

  // ---------------- converter ----------------
  logic             conv_busy;
  logic             conv_done;
  logic             conv_ovf_q;   // overflow flag travelling with the conversion
  logic [BCD_W-1:0] d3, d2, d1, d0;

  bcd_seq_converter u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (handoff),
    .bin   (cnt_sum),
    .busy  (conv_busy),
    .done  (conv_done),
    .d3    (d3),
    .d2    (d2),
    .d1    (d1),
    .d0    (d0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        conv_ovf_q <= 1'b0;
    else if (handoff && !conv_busy) conv_ovf_q <= ovf_sum;
  end

  // ---------------- publish registers ----------------
  bcd4_t pub_q;
  logic  pub_ovf_q;
  logic  update_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pub_q     <= '0;
      pub_ovf_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      update_q <= conv_done;
      if (conv_done) begin
        pub_q     <= '{thousands: d3, hundreds: d2, tens: d1, ones: d0};
        pub_ovf_q <= conv_ovf_q;
      end
    end
  end

  assign bus.thousands   = pub_q.thousands;
  assign bus.hundreds    = pub_q.hundreds;
  assign bus.tens        = pub_q.tens;
  assign bus.ones        = pub_q.ones;
  assign bus.overflow    = pub_ovf_q;
  assign bus.update      = update_q;
  assign bus.gate_active = (gate_state == G_OPEN);

endmodule

// File: tb/tb_mic_measure_sequencer.sv
// Bench for mic_measure_sequencer.
// dut_a (GATE_CYCLES=100) runs against a cycle-level reference model that
// knows only the externally visible rules: gate_active follows enable one
// cycle later, mic rises are seen SYNC cycles late, each completed window's
// edge total is published (saturated) 16 cycles after its last cycle.
// dut_b (GATE_CYCLES=25000) covers saturation with directed expectations.
module tb_mic_measure_sequencer;
  import mic_pkg::*;

  localparam int G_A   = 100;
  localparam int G_B   = 25000;
  localparam int SYNC  = 2;
  localparam int MAX_C = 9999;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mic_measure_sequencer_if bus_a ();
  mic_measure_sequencer_if bus_b ();

  mic_measure_sequencer #(.GATE_CYCLES(G_A), .SYNC_STAGES(SYNC), .MAX_COUNT(MAX_C)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mic_measure_sequencer #(.GATE_CYCLES(G_B), .SYNC_STAGES(SYNC), .MAX_COUNT(MAX_C)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // ---------------- reference model for dut_a ----------------
  typedef struct {
    int due;
    int val;
    bit ovf;
  } pub_t;

  pub_t q[$];
  logic mh[0:7];          // mh[j] = mic_in sampled j edges ago
  bit   en_cur, en_prev;
  int   pos_cur, pos_prev;
  int   cnt;              // raw edges in the open window, unsaturated
  int   cyc = 0;
  int   pub_val = 0;
  bit   pub_ovf = 1'b0;

  always @(posedge clk) begin
    logic pulse;
    bit   exp_upd;
    #1;
    cyc++;
    if (rst) begin
      for (int i = 0; i < 8; i++) mh[i] = 1'b0;
      en_cur = 0; en_prev = 0; pos_cur = 0; pos_prev = 0; cnt = 0;
      q.delete();
      pub_val = 0; pub_ovf = 0;
      check("a_rst_update", bus_a.update, 0);
      check("a_rst_digits", {bus_a.thousands, bus_a.hundreds, bus_a.tens, bus_a.ones}, 0);
    end else begin
      for (int i = 7; i > 0; i--) mh[i] = mh[i-1];
      mh[0]   = bus_a.mic_in;
      en_prev = en_cur;
      en_cur  = bus_a.enable;
      pulse   = mh[SYNC] & ~mh[SYNC+1];
      if (en_prev) begin
        if (pulse) cnt++;
        if (!en_cur) cnt = 0;
        else if (pos_prev == G_A - 1) begin
          if (q.size() == 0)
            q.push_back('{due: cyc + 15, val: (cnt > MAX_C) ? MAX_C : cnt, ovf: (cnt > MAX_C)});
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
      pos_cur  = (en_cur && en_prev) ? (pos_prev + 1) % G_A : 0;
      pos_prev = pos_cur;
      exp_upd  = (q.size() > 0) && (q[0].due == cyc);
      if (exp_upd) begin
        pub_val = q[0].val;
        pub_ovf = q[0].ovf;
        void'(q.pop_front());
      end
      check("a_gate_active", bus_a.gate_active, en_cur);
      check("a_update", bus_a.update, exp_upd);
      check("a_digits", {bus_a.thousands, bus_a.hundreds, bus_a.tens, bus_a.ones}, to_bcd(pub_val));
      check("a_overflow", bus_a.overflow, pub_ovf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(en_cur && pos_cur == p) && n < 4 * G_A);
    check("a_wait_pos", (en_cur && pos_cur == p), 1);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_gate"}, bus_a.gate_active, 0);
    check({tag, "_update"}, bus_a.update, 0);
    check({tag, "_ovf"}, bus_a.overflow, 0);
    check({tag, "_digits"}, {bus_a.thousands, bus_a.hundreds, bus_a.tens, bus_a.ones}, 0);
  endtask

  task automatic wait_upd_b(input int limit, output bit seen);
    seen = 0;
    for (int n = 0; n < limit && !seen; n++) begin
      @(posedge clk);
      #1;
      if (bus_b.update) seen = 1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    int t1, t2, n;

    rst = 1'b1;
    bus_a.enable = 0; bus_a.mic_in = 0;
    bus_b.enable = 0; bus_b.mic_in = 0;
    repeat (3) @(negedge clk);
    check_zero_a("a_reset");
    check("b_reset_digits", {bus_b.thousands, bus_b.hundreds, bus_b.tens, bus_b.ones}, 0);
    check("b_reset_gate", bus_b.gate_active, 0);
    rst = 1'b0;

    // mic period 10: every window holds exactly 10 rising edges
    for (int i = 0; i < 5 * G_A + 30; i++) begin
      @(negedge clk);
      bus_a.enable = 1;
      bus_a.mic_in = (i % 10) < 5;
    end

    // one edge landing in the last window cycle, then a quiet window
    bus_a.mic_in = 0;
    wait_pos(G_A - 3);
    wait_pos(G_A - 3);
    bus_a.mic_in = 1;
    repeat (30) @(negedge clk);
    bus_a.mic_in = 0;
    // one edge landing in cycle 0 of the next window
    wait_pos(G_A - 3);
    wait_pos(G_A - 2);
    bus_a.mic_in = 1;
    repeat (30) @(negedge clk);
    bus_a.mic_in = 0;
    wait_pos(G_A - 1);

    // abort at window cycle 50 with edges already counted, then re-enable
    wait_pos(0);
    while (pos_cur != 50 && en_cur) begin
      @(negedge clk);
      bus_a.mic_in = 1'($urandom_range(0, 1));
    end
    bus_a.enable = 0;
    repeat (30) begin
      @(negedge clk);
      bus_a.mic_in = 1'($urandom_range(0, 1));
    end
    bus_a.enable = 1;
    repeat (2 * G_A + 40) begin
      @(negedge clk);
      bus_a.mic_in = 1'($urandom_range(0, 1));
    end

    // random mic activity with occasional enable drops
    for (int i = 0; i < 8 * G_A; i++) begin
      @(negedge clk);
      bus_a.mic_in = ($urandom_range(0, 2) == 0) ? ~bus_a.mic_in : bus_a.mic_in;
      bus_a.enable = ($urandom_range(0, 149) != 0);
    end
    bus_a.enable = 1;

    // reset while the converter is shifting a nonzero count
    n = 0;
    while (q.size() == 0 && n < 3 * G_A) begin
      @(negedge clk);
      bus_a.mic_in = 1'($urandom_range(0, 1));
      n++;
    end
    check("a_wait_conv", q.size() > 0, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero_a("a_rst_shift");
    bus_a.enable = 0; bus_a.mic_in = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    bus_a.enable = 1;
    repeat (G_A + 30) @(negedge clk);

    // reset in the middle of a window
    wait_pos(37);
    #2 rst = 1'b1;
    #1 check_zero_a("a_rst_window");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * G_A + 40) begin
      @(negedge clk);
      bus_a.mic_in = 1'($urandom_range(0, 1));
    end
    bus_a.enable = 0;
    repeat (5) @(negedge clk);

    // saturation on dut_b: mic toggling every cycle, then a quiet window
    bus_b.enable = 1;
    repeat (3) @(negedge clk);
    check("b_gate_open", bus_b.gate_active, 1);
    for (int i = 0; i < G_B - 13; i++) begin
      @(negedge clk);
      bus_b.mic_in = ~bus_b.mic_in;
    end
    bus_b.mic_in = 0;
    wait_upd_b(500, seen);
    check("b_sat_update_seen", seen, 1);
    t1 = cyc;
    check("b_sat_digits", {bus_b.thousands, bus_b.hundreds, bus_b.tens, bus_b.ones}, 16'h9999);
    check("b_sat_overflow", bus_b.overflow, 1);
    @(posedge clk);
    #1;
    check("b_strobe_len", bus_b.update, 0);
    check("b_hold_digits", {bus_b.thousands, bus_b.hundreds, bus_b.tens, bus_b.ones}, 16'h9999);
    wait_upd_b(G_B + 500, seen);
    check("b_quiet_update_seen", seen, 1);
    t2 = cyc;
    check("b_update_period", t2 - t1, G_B);
    check("b_quiet_digits", {bus_b.thousands, bus_b.hundreds, bus_b.tens, bus_b.ones}, 0);
    check("b_quiet_overflow", bus_b.overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
